ita_hwpe_output_arbiter: RTL and testbench
==========================================

Name: ita_hwpe_output_arbiter

Overview:
Shares the single output packing buffer and its output stream between NUM_REQ result producers, for example the requant output and the softmax/auxiliary output.
Grants one requester at a time and locks the grant for a full burst of BURST_LEN beats, so a packed output word never mixes data from two sources.
Sits directly upstream of the output packing buffer, inside the HWPE wrapper.

Parameters:
NUM_REQ, 2, number of requesting streams (>=2)
DATA_WIDTH, 32, per-beat data width in bits (multiple of 8)
BURST_LEN, 2, beats per locked grant; equals the output buffer packing factor (>=1)
IDX_W, $clog2(NUM_REQ), width of the grant index

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous abort; returns the block to IDLE
in_valid_i  in  NUM_REQ  per-requester valid
in_ready_o  out  NUM_REQ  per-requester ready
in_data_i  in  NUM_REQ*DATA_WIDTH  requester data, requester r at bits [r*DATA_WIDTH +: DATA_WIDTH]
in_strb_i  in  NUM_REQ*DATA_WIDTH/8  requester byte strobes
out_valid_o  out  1  valid to the output buffer
out_ready_i  in  1  ready from the output buffer
out_data_o  out  DATA_WIDTH  muxed data
out_strb_o  out  DATA_WIDTH/8  muxed strobes
grant_o  out  IDX_W  current or pending owner index
busy_o  out  1  high while in LOCKED

Behaviour:
- Clocking and reset: one clock, clk_i. rst_ni is asynchronous and active-low.
- Reset values: state=IDLE, rr_ptr=0, beat_cnt=0, owner=0. Hence out_valid_o=0, in_ready_o=0, grant_o=0, busy_o=0, out_data_o=0, out_strb_o=0.
- State IDLE:
  - winner = first requester with valid high, searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - Zero-latency pass-through: out_valid_o = in_valid_i[winner]; data and strobes come from winner; in_ready_o[winner] = out_ready_i; all other readies = 0; grant_o = winner.
  - On handshake (out_valid_o & out_ready_i):
    - BURST_LEN==1: stay IDLE, rr_ptr = (winner+1) mod NUM_REQ.
    - Otherwise: owner=winner, beat_cnt=1, go to LOCKED.
  - No valid requester: all outputs 0, no state change.
- State LOCKED:
  - Only the owner is connected. Other requesters see ready=0, even if valid.
  - Owner valid low mid-burst: out_valid_o=0 and the lock is held indefinitely; no switch to another requester.
  - Each handshake increments beat_cnt.
  - Handshake with beat_cnt==BURST_LEN-1: beat_cnt=0, rr_ptr=(owner+1) mod NUM_REQ, go to IDLE. The next burst is arbitrated in the following cycle; no bubble beyond that cycle.
- Data and strobes are purely combinational muxes of the granted requester. They are zero when nothing is granted.
- Backpressure: out_ready_i low leaves state, beat_cnt and mux selection unchanged. Data must stay stable while out_valid_o is high.
- clear_i has priority over all state updates: state=IDLE, beat_cnt=0, rr_ptr unchanged. While clear_i is high, all readies are forced to 0 and out_valid_o to 0.
- Reset mid-burst: immediate return to the reset values. Partially transferred beats are lost.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,... one burst each.
- beat_cnt width: $clog2(BURST_LEN+1).
- A requester's data must not change until its in_ready_o is sampled high (upstream obligation). Assertions check this in simulation.

Optional Feature:
Macro ITA_OUT_ARB_FIXED_PRIO_EN.
- Defined: winner is the lowest-index valid requester and rr_ptr is unused (held at 0). Burst locking is unchanged.
- Undefined: round-robin as specified above.

Decomposition:
- ita_package: typedef enum {ARB_IDLE, ARB_LOCKED} ita_out_arb_state_e; localparam default burst length equal to the output buffer packing factor, shared with the output buffer.
- Sub-module ita_rr_select: combinational, with inputs valid vector and pointer, outputs winner index and any-valid. Implements wrap-around priority search; the fixed-priority variant is a pointer forced to 0.
- Top module: state register, beat counter, owner/rr_ptr registers, muxes.

Test Plan:
- Reset and idle: no valids -> out_valid_o=0, all in_ready_o=0, grant_o=0, busy_o=0 for 10 cycles.
- Burst lock: NUM_REQ=2, BURST_LEN=2; req0 sends 0xA0,0xA1 while req1 valid throughout -> output sequence 0xA0,0xA1, then req1's 0xB0,0xB1; in_ready_o[1]=0 during the req0 burst.
- Round-robin wrap: NUM_REQ=3, all valid, 6 bursts -> grant order 0,1,2,0,1,2; rr_ptr wraps 2->0.
- Stall mid-burst: req0 drops valid after beat 1 for 5 cycles, req1 valid -> out_valid_o=0, lock held, busy_o=1; req0 beat 2 is then delivered before any req1 beat.
- Backpressure: out_ready_i low for 4 cycles with req0 valid (data 0x55, strb 0xF) -> out_data_o=0x55 and out_strb_o=0xF stable, beat_cnt unchanged.
- Clear mid-burst: clear_i pulsed after beat 1 of req1 -> next cycle state IDLE, busy_o=0; the next burst is granted by the search from the unchanged rr_ptr. Repeat with ITA_OUT_ARB_FIXED_PRIO_EN: req0 always wins when valid.

Source files
------------

// File: rtl/ita_hwpe_output_arbiter_pkg.sv
// Shared types and constants for the HWPE output arbiter and output packing buffer.
// The default burst length equals the packing factor of the output buffer.
package ita_hwpe_output_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } ita_out_arb_state_e;

    localparam int unsigned ITA_OUT_BURST_LEN = 2;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ita_hwpe_output_arbiter_if.sv
// Request/output stream bundle between result producers, the arbiter and the output buffer.
interface ita_hwpe_output_arbiter_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]              in_valid_i;
    logic [NUM_REQ-1:0]              in_ready_o;
    logic [NUM_REQ*DATA_WIDTH-1:0]   in_data_i;
    logic [NUM_REQ*DATA_WIDTH/8-1:0] in_strb_i;
    logic                            out_valid_o;
    logic                            out_ready_i;
    logic [DATA_WIDTH-1:0]           out_data_o;
    logic [DATA_WIDTH/8-1:0]         out_strb_o;

    modport slave (
        input  in_valid_i, in_data_i, in_strb_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_strb_o
    );

    modport master (
        output in_valid_i, in_data_i, in_strb_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_strb_o
    );
endinterface

// File: rtl/ita_hwpe_output_arbiter_rr_select.sv
// Wrap-around priority search: first valid requester at or above ptr_i, wrapping to 0.
// A pointer tied to 0 gives plain lowest-index priority.
module ita_hwpe_output_arbiter_rr_select #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               any_o
);

    function automatic int unsigned rot_idx(input int unsigned ptr, input int unsigned k);
        int unsigned s;
        s = ptr + k;
        return (s >= NUM_REQ) ? s - NUM_REQ : s;
    endfunction

    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!any_o && valid_i[rot_idx(32'(ptr_i), k)]) begin
                winner_o = IDX_W'(rot_idx(32'(ptr_i), k));
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ita_hwpe_output_arbiter.sv
// Burst-locked arbiter sharing the output packing buffer between NUM_REQ producers.
// Define ITA_OUT_ARB_FIXED_PRIO_EN for lowest-index priority instead of round-robin.
//
// state      | meaning
// ARB_IDLE   | arbitrating; winner passes through with zero latency
// ARB_LOCKED | owner holds the output until BURST_LEN beats are transferred
module ita_hwpe_output_arbiter
    import ita_hwpe_output_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = ITA_OUT_BURST_LEN,
    parameter int unsigned IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    ita_hwpe_output_arbiter_if.slave bus,
    output logic [IDX_W-1:0]         grant_o,
    output logic                     busy_o
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = $clog2(BURST_LEN + 1);

    ita_out_arb_state_e r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [IDX_W-1:0]   r_owner, w_owner_nxt;
    logic [CNT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;
    logic [IDX_W-1:0]   w_ptr, w_winner, w_sel;
    logic               w_any, w_active, w_hs;

`ifdef ITA_OUT_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    assign w_ptr = r_rr_ptr;
`endif

    ita_hwpe_output_arbiter_rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .valid_i  (bus.in_valid_i),
        .ptr_i    (w_ptr),
        .winner_o (w_winner),
        .any_o    (w_any)
    );

    // The owner stays connected while locked even if its valid drops mid-burst.
    assign w_active        = (r_state == ARB_LOCKED) | w_any;
    assign w_sel           = (r_state == ARB_LOCKED) ? r_owner : w_winner;
    assign bus.out_valid_o = w_active & bus.in_valid_i[w_sel] & ~clear_i;
    assign w_hs            = bus.out_valid_o & bus.out_ready_i;
    assign grant_o         = w_active ? w_sel : '0;
    assign busy_o          = (r_state == ARB_LOCKED);

    always_comb begin
        bus.out_data_o = '0;
        bus.out_strb_o = '0;
        bus.in_ready_o = '0;
        if (w_active) begin
            bus.out_data_o        = bus.in_data_i[w_sel*DATA_WIDTH +: DATA_WIDTH];
            bus.out_strb_o        = bus.in_strb_i[w_sel*STRB_W +: STRB_W];
            bus.in_ready_o[w_sel] = bus.out_ready_i & ~clear_i;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_beat_cnt_nxt = r_beat_cnt;
        if (clear_i) begin
            w_state_nxt    = ARB_IDLE;
            w_beat_cnt_nxt = '0;
        end else if (w_hs) begin
            unique case (r_state)
                ARB_IDLE: begin
                    if (BURST_LEN == 1) begin
                        w_rr_ptr_nxt = IDX_W'(wrap_inc(32'(w_winner), NUM_REQ));
                    end else begin
                        w_owner_nxt    = w_winner;
                        w_beat_cnt_nxt = CNT_W'(1);
                        w_state_nxt    = ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (r_beat_cnt == CNT_W'(BURST_LEN - 1)) begin
                        w_beat_cnt_nxt = '0;
                        w_rr_ptr_nxt   = IDX_W'(wrap_inc(32'(r_owner), NUM_REQ));
                        w_state_nxt    = ARB_IDLE;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = ARB_IDLE;
            endcase
        end
`ifdef ITA_OUT_ARB_FIXED_PRIO_EN
        w_rr_ptr_nxt = '0;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ARB_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // Producers must hold a pending beat until it is accepted.
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_hold_chk
        a_in_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (bus.in_valid_i[r] && !bus.in_ready_o[r]) |=>
                ($stable(bus.in_data_i[r*DATA_WIDTH +: DATA_WIDTH]) &&
                 $stable(bus.in_strb_i[r*STRB_W +: STRB_W])));
    end

endmodule

// File: tb/tb_ita_hwpe_output_arbiter.sv
// Directed bench for ita_hwpe_output_arbiter (3 requesters, burst of 2) with a
// transaction-level reference model checked every cycle.
module tb_ita_hwpe_output_arbiter;
    localparam int N  = 3;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int BL = 2;
    localparam int IW = 2;
`ifdef ITA_OUT_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
    localparam int CLR_GRANT = 0;
`else
    localparam bit FIXED = 1'b0;
    localparam int CLR_GRANT = 1;
`endif

    logic          clk_i   = 1'b0;
    logic          rst_ni  = 1'b1;
    logic          clear_i = 1'b0;
    logic [IW-1:0] grant_o;
    logic          busy_o;

    ita_hwpe_output_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    ita_hwpe_output_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .bus     (bus),
        .grant_o (grant_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] src_d [N][16];
    logic [SW-1:0] src_s [N][16];
    int            src_rd [N];
    int            src_wr [N];
    logic [N-1:0]  en = '1;
    logic [N-1:0]  hs_in = '0;
    logic [DW-1:0] out_log [$];
    logic [DW-1:0] exp_q [$];
    int            start;

    // reference model: current burst owner (-1 = none), beats done, rotation pointer
    int m_owner = -1;
    int m_done  = 0;
    int m_rr    = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int r, input logic [DW-1:0] d, input logic [SW-1:0] s);
        src_d[r][src_wr[r]] = d;
        src_s[r][src_wr[r]] = s;
        src_wr[r]++;
    endtask

    function automatic bit all_empty();
        for (int r = 0; r < N; r++) if (src_rd[r] != src_wr[r]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            bus.in_valid_i[r] = en[r] && (src_rd[r] != src_wr[r]);
            if (src_rd[r] != src_wr[r]) begin
                bus.in_data_i[r*DW +: DW] = src_d[r][src_rd[r]];
                bus.in_strb_i[r*SW +: SW] = src_s[r][src_rd[r]];
            end
        end
    endtask

    task automatic compare_cycle();
        int            w, sel, base;
        logic          ev;
        logic [N-1:0]  er;
        if (!rst_ni) begin
            m_owner = -1; m_done = 0; m_rr = 0; hs_in = '0;
            return;
        end
        base = FIXED ? 0 : m_rr;
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && bus.in_valid_i[(base + k) % N]) w = (base + k) % N;
        sel = (m_owner >= 0) ? m_owner : w;
        ev  = !clear_i && sel >= 0 && bus.in_valid_i[sel];
        er  = '0;
        if (!clear_i && sel >= 0) er[sel] = bus.out_ready_i;
        check("out_valid", bus.out_valid_o, ev);
        check("in_ready", bus.in_ready_o, er);
        check("grant", grant_o, (sel >= 0) ? sel : 0);
        check("busy", busy_o, m_owner >= 0);
        if (ev) begin
            check("out_data", bus.out_data_o, bus.in_data_i[sel*DW +: DW]);
            check("out_strb", bus.out_strb_o, bus.in_strb_i[sel*SW +: SW]);
        end else if (sel < 0) begin
            check("out_data_zero", bus.out_data_o, 0);
            check("out_strb_zero", bus.out_strb_o, 0);
        end
        hs_in = bus.in_valid_i & bus.in_ready_o;
        if (bus.out_valid_o && bus.out_ready_i) out_log.push_back(bus.out_data_o);
        if (clear_i) begin
            m_owner = -1; m_done = 0;
        end else if (ev && bus.out_ready_i) begin
            if (m_owner < 0) m_owner = sel;
            m_done++;
            if (m_done == BL) begin
                m_rr = (m_owner + 1) % N; m_owner = -1; m_done = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        compare_cycle();
        @(posedge clk_i);
        #1;
        for (int r = 0; r < N; r++) if (hs_in[r]) src_rd[r]++;
        drive();
    endtask

    task automatic drain(input string name, input int max_cyc);
        int n = 0;
        while (n < max_cyc && !(all_empty() && m_owner < 0)) begin
            tick();
            n++;
        end
        check({"drain_", name}, all_empty() && m_owner < 0, 1);
    endtask

    task automatic check_log(input string name, input int from);
        check({name, "_len"}, out_log.size() - from, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (from + i < out_log.size()) check({name, "_beat"}, out_log[from + i], exp_q[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid_i  = '0;
        bus.in_data_i   = '0;
        bus.in_strb_i   = '0;
        bus.out_ready_i = 1'b1;
        drive();
        #1 rst_ni = 1'b0;
        #1;
        check("rst_valid", bus.out_valid_o, 0);
        check("rst_ready", bus.in_ready_o, 0);
        check("rst_grant", grant_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_data", bus.out_data_o, 0);
        check("rst_strb", bus.out_strb_o, 0);
        tick(); tick();
        rst_ni = 1'b1;

        // idle with no requesters
        repeat (10) tick();
        #1;
        check("idle_valid", bus.out_valid_o, 0);
        check("idle_busy", busy_o, 0);

        // burst lock: req1 waits for req0's full burst
        start = out_log.size();
        push(0, 32'hA0, 4'hF); push(0, 32'hA1, 4'hF);
        push(1, 32'hB0, 4'hF); push(1, 32'hB1, 4'hF);
        drive();
        tick();
        #1;
        check("lock_rdy1", bus.in_ready_o[1], 0);
        check("lock_busy", busy_o, 1);
        drain("lock", 20);
        exp_q = '{32'hA0, 32'hA1, 32'hB0, 32'hB1};
        check_log("lock_log", start);

        // rotation over three always-valid requesters, from a fresh pointer
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        start = out_log.size();
        for (int r = 0; r < N; r++)
            for (int k = 0; k < 4; k++) push(r, 32'hC00 + 32'(r * 16 + k), 4'hF);
        drive();
        drain("rr", 40);
        exp_q = {};
`ifdef ITA_OUT_ARB_FIXED_PRIO_EN
        for (int r = 0; r < N; r++)
            for (int k = 0; k < 4; k++) exp_q.push_back(32'hC00 + 32'(r * 16 + k));
`else
        for (int b = 0; b < 6; b++)
            for (int j = 0; j < 2; j++) exp_q.push_back(32'hC00 + 32'((b % 3) * 16 + (b / 3) * 2 + j));
`endif
        check_log("rr_log", start);

        // owner stalls mid-burst; lock must hold
        start = out_log.size();
        push(0, 32'hD0, 4'hF); push(0, 32'hD1, 4'hF);
        push(1, 32'hE0, 4'hF); push(1, 32'hE1, 4'hF);
        drive();
        tick();
        en[0] = 1'b0;
        drive();
        repeat (5) begin
            #1;
            check("stall_busy", busy_o, 1);
            check("stall_valid", bus.out_valid_o, 0);
            check("stall_rdy1", bus.in_ready_o[1], 0);
            tick();
        end
        en[0] = 1'b1;
        drive();
        drain("stall", 20);
        exp_q = '{32'hD0, 32'hD1, 32'hE0, 32'hE1};
        check_log("stall_log", start);

        // backpressure before and inside a burst
        start = out_log.size();
        push(0, 32'h55, 4'hF); push(0, 32'h56, 4'hF);
        bus.out_ready_i = 1'b0;
        drive();
        repeat (4) begin
            #1;
            check("bp_data", bus.out_data_o, 32'h55);
            check("bp_strb", bus.out_strb_o, 4'hF);
            check("bp_valid", bus.out_valid_o, 1);
            check("bp_busy", busy_o, 0);
            tick();
        end
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        repeat (2) begin
            #1;
            check("bp_data2", bus.out_data_o, 32'h56);
            check("bp_busy2", busy_o, 1);
            tick();
        end
        bus.out_ready_i = 1'b1;
        drain("bp", 20);
        exp_q = '{32'h55, 32'h56};
        check_log("bp_log", start);

        // clear after the first beat of req1's burst
        start = out_log.size();
        en[0] = 1'b0;
        push(1, 32'hF0, 4'hF); push(1, 32'hF1, 4'hF); push(1, 32'hF2, 4'hF);
        push(0, 32'h90, 4'h3); push(0, 32'h91, 4'hC);
        drive();
        tick();
        en[0]   = 1'b1;
        clear_i = 1'b1;
        drive();
        #1;
        check("clr_valid", bus.out_valid_o, 0);
        check("clr_ready", bus.in_ready_o, 0);
        tick();
        clear_i = 1'b0;
        #1;
        check("clr_busy", busy_o, 0);
        check("clr_grant", grant_o, CLR_GRANT);
        drain("clr", 30);
`ifdef ITA_OUT_ARB_FIXED_PRIO_EN
        exp_q = '{32'hF0, 32'h90, 32'h91, 32'hF1, 32'hF2};
`else
        exp_q = '{32'hF0, 32'hF1, 32'hF2, 32'h90, 32'h91};
`endif
        check_log("clr_log", start);

        // reset mid-burst drops the lock
        start = out_log.size();
        push(2, 32'h70, 4'hF); push(2, 32'h71, 4'hF); push(2, 32'h72, 4'hF);
        drive();
        tick();
        rst_ni = 1'b0;
        #1;
        check("rstm_busy", busy_o, 0);
        tick();
        rst_ni = 1'b1;
        drain("rstm", 20);
        exp_q = '{32'h70, 32'h71, 32'h72};
        check_log("rstm_log", start);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
